seq_rx_checker: RTL and testbench

Receiving-side checker for the 3-bit cyclic state code produced by the team's sequence-generator FSMs (legal cycle 0 → 2 → 6 → 3 → 0). It samples the code stream on a valid strobe and locks onto the cycle. It then counts completed laps, flags and counts sequence errors, and raises a sticky alarm on the forbidden codes where bit2 and bit0 are both set. It sits beside the generator as an on-chip monitor and gives the formal flow a concrete observer.

---
 rtl/seq_rx_checker.sv | 110 +++++++++++
 tb/tb_seq_rx_checker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_rx_checker.sv
// Receive-side checker for the 0-2-6-3 cyclic state code.
// Locks onto the cycle, counts laps and errors, flags forbidden codes.
module seq_rx_checker #(
  parameter int CNT_W    = 8,
  parameter int LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [2:0]       code,
  output logic             locked,
  output logic             hunting,
  output logic             err,
  output logic             alarm,
  output logic [CNT_W-1:0] lap_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    HUNT,
    GOT0,
    GOT2,
    GOT6,
    GOT3
  } state_t;

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_LEN);

  state_t           state_q, state_d;
  state_t           nxt;
  logic [2:0]       exp_code;
  logic [3:0]       run_q, run_d;
  logic             locked_d, err_d, alarm_d;
  logic [CNT_W-1:0] lap_d, errc_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
      run_q   <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      alarm   <= 1'b0;
      lap_cnt <= '0;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      locked  <= locked_d;
      err     <= err_d;
      alarm   <= alarm_d;
      lap_cnt <= lap_d;
      err_cnt <= errc_d;
    end
  end

  assign hunting = (state_q == HUNT);

  always_comb begin
    exp_code = 3'd0;
    nxt      = HUNT;
    unique case (state_q)
      GOT0: begin exp_code = 3'd2; nxt = GOT2; end
      GOT2: begin exp_code = 3'd6; nxt = GOT6; end
      GOT6: begin exp_code = 3'd3; nxt = GOT3; end
      GOT3: begin exp_code = 3'd0; nxt = GOT0; end
      default: begin exp_code = 3'd0; nxt = GOT0; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    locked_d = locked;
    err_d    = 1'b0;
    alarm_d  = alarm;
    lap_d    = lap_cnt;
    errc_d   = err_cnt;
    if (valid) begin
      if (code[2] & code[0]) alarm_d = 1'b1;
      if (state_q == HUNT) begin
        if (code == 3'd0) begin
          state_d = GOT0;
          run_d   = 4'd1;
        end else begin
          run_d   = 4'd0;
        end
      end else if (code == exp_code) begin
        state_d = nxt;
        run_d   = (run_q >= LOCK_RUN) ? LOCK_RUN : run_q + 4'd1;
        if (run_d == LOCK_RUN) locked_d = 1'b1;
        // a lap closes on the 3 -> 0 step, only if already locked
        if (state_q == GOT3 && locked) lap_d = lap_cnt + 1'b1;
      end else begin
        if (locked) begin
          err_d = 1'b1;
          if (err_cnt != '1) errc_d = err_cnt + 1'b1;
        end
        locked_d = 1'b0;
        if (code == 3'd0) begin
          state_d = GOT0;
          run_d   = 4'd1;
        end else begin
          state_d = HUNT;
          run_d   = 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_rx_checker.sv
// Directed bench for seq_rx_checker: lock, laps, errors, alarm,
// gapped valid, counter wrap/saturation and async reset.
module tb_seq_rx_checker;

  logic       clk;
  logic       reset;
  logic       valid;
  logic [2:0] code;

  logic       locked, hunting, err, alarm;
  logic [7:0] lap_cnt, err_cnt;
  logic       locked3, hunting3, err3, alarm3;
  logic [2:0] lap_cnt3, err_cnt3;

  int tests = 0;
  int fails = 0;

  seq_rx_checker #(.CNT_W(8), .LOCK_LEN(4)) u8 (
    .clk(clk), .reset(reset), .valid(valid), .code(code),
    .locked(locked), .hunting(hunting), .err(err), .alarm(alarm),
    .lap_cnt(lap_cnt), .err_cnt(err_cnt)
  );

  seq_rx_checker #(.CNT_W(3), .LOCK_LEN(4)) u3 (
    .clk(clk), .reset(reset), .valid(valid), .code(code),
    .locked(locked3), .hunting(hunting3), .err(err3), .alarm(alarm3),
    .lap_cnt(lap_cnt3), .err_cnt(err_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] c);
    valid = v;
    code  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic seq4();
    step(1'b1, 3'd0);
    step(1'b1, 3'd2);
    step(1'b1, 3'd6);
    step(1'b1, 3'd3);
  endtask

  task automatic do_reset();
    valid = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  logic [2:0] s1 [9] = '{3'd0, 3'd2, 3'd6, 3'd3, 3'd0,
                         3'd2, 3'd6, 3'd3, 3'd0};
  logic [2:0] s4 [4] = '{3'd0, 3'd2, 3'd6, 3'd3};

  initial begin
    reset = 1'b0;
    valid = 1'b0;
    code  = 3'd0;
    #12;
    reset = 1'b1;

    // reset values
    chk("rst_locked", locked, 0);
    chk("rst_hunting", hunting, 1);
    chk("rst_err", err, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_lap", lap_cnt, 0);
    chk("rst_errcnt", err_cnt, 0);

    // clean stream, lock and two laps
    for (int i = 0; i < 9; i++) begin
      step(1'b1, s1[i]);
      chk("s1_err", err, 0);
      if (i == 0) chk("s1_hunt0", hunting, 0);
      if (i == 2) chk("s1_nolock3", locked, 0);
      if (i == 3) chk("s1_lock4", locked, 1);
      if (i == 4) chk("s1_lap1", lap_cnt, 1);
      if (i == 8) chk("s1_lap2", lap_cnt, 2);
    end

    // mismatch while locked: 6 where 3 expected
    step(1'b1, 3'd2);
    step(1'b1, 3'd6);
    step(1'b1, 3'd6);
    chk("mm_err", err, 1);
    chk("mm_errcnt", err_cnt, 1);
    chk("mm_locked", locked, 0);
    chk("mm_hunting", hunting, 1);
    step(1'b1, 3'd0);
    chk("mm_err_pulse", err, 0);
    chk("mm_resync", hunting, 0);
    step(1'b1, 3'd2);
    step(1'b1, 3'd6);
    step(1'b1, 3'd3);
    chk("mm_relock", locked, 1);
    chk("mm_errcnt_hold", err_cnt, 1);
    chk("mm_lap_hold", lap_cnt, 2);

    // forbidden code while locked
    do_reset();
    seq4();
    chk("al_lock", locked, 1);
    step(1'b1, 3'd5);
    chk("al_alarm", alarm, 1);
    chk("al_err", err, 1);
    chk("al_errcnt", err_cnt, 1);
    chk("al_hunting", hunting, 1);
    seq4();
    for (int i = 0; i < 10; i++) seq4();
    chk("al_laps", lap_cnt, 10);
    chk("al_sticky", alarm, 1);
    chk("al_errcnt_hold", err_cnt, 1);
    do_reset();
    chk("al_cleared", alarm, 0);

    // gaps in valid with junk codes on invalid cycles
    for (int i = 0; i < 4; i++) begin
      step(1'b1, s4[i]);
      chk("gap_err", err, 0);
      if (i == 2) chk("gap_nolock", locked, 0);
      if (i == 3) chk("gap_lock", locked, 1);
      step(1'b0, 3'($urandom_range(0, 7)));
      chk("gap_err_inv", err, 0);
      chk("gap_alarm", alarm, 0);
    end
    chk("gap_lock_hold", locked, 1);

    // lap wrap and err_cnt saturation (3-bit instance)
    do_reset();
    seq4();
    for (int i = 0; i < 9; i++) seq4();
    chk("wrap_lap8", lap_cnt, 9);
    chk("wrap_lap3", lap_cnt3, 1);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 3'd6);
      chk("sat_err", err3, 1);
      seq4();
    end
    chk("sat_errcnt8", err_cnt, 9);
    chk("sat_errcnt3", err_cnt3, 7);
    chk("sat_relock", locked3, 1);

    // async reset mid-lap
    do_reset();
    seq4();
    seq4();
    seq4();
    step(1'b1, 3'd0);
    step(1'b1, 3'd2);
    step(1'b1, 3'd6);
    chk("ar_pre_lap", lap_cnt, 3);
    chk("ar_pre_lock", locked, 1);
    reset = 1'b0;
    #2;
    chk("ar_locked", locked, 0);
    chk("ar_hunting", hunting, 1);
    chk("ar_lap", lap_cnt, 0);
    chk("ar_errcnt", err_cnt, 0);
    chk("ar_err", err, 0);
    chk("ar_alarm", alarm, 0);
    #2;
    reset = 1'b1;
    step(1'b1, 3'd3);
    chk("ar_lead3", hunting, 1);
    step(1'b1, 3'd0);
    chk("ar_got0", hunting, 0);
    chk("ar_nolock", locked, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
